sio_ate_gen: RTL and testbench



---
 rtl/sio_ate_gen.sv | 151 +++++++++++++++
 tb/tb_sio_ate_gen.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sio_ate_gen.sv
// ============================================================================
// sio_ate_gen : multi-channel framed serial (SIO) test-pattern generator.
// Optional even-parity cycle per frame: define SIO_ATE_PARITY_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module sio_ate_gen #(
  parameter int DATA_WIDTH   = 10,
  parameter int PREAMBLE_LEN = 20,
  parameter int NCHAN        = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                          SioClk,
  input  logic                          Reset,
  input  logic                          Start,
  input  logic                          Continuous,
  input  logic [NCHAN*DATA_WIDTH-1:0]   TestWord,
  output logic [NCHAN-1:0]              SioDat,
  output logic                          Busy,
  output logic                          FrameDone,
  output logic [CNT_WIDTH-1:0]          FrameCount
);

  localparam int MAXLEN = (PREAMBLE_LEN > DATA_WIDTH) ? PREAMBLE_LEN : DATA_WIDTH;
  localparam int CW     = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam logic [CW-1:0] PRE_LAST  = CW'(PREAMBLE_LEN - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRE    = 3'd1,
    S_START  = 3'd2,
`ifdef SIO_ATE_PARITY_EN
    S_DATA   = 3'd3,
    S_PARITY = 3'd4
`else
    S_DATA   = 3'd3
`endif
  } state_t;

  // The state register runs one edge ahead of the registered outputs: the
  // state held after an edge names the symbol presented at the next edge.
  state_t                               state_q;
  logic [CW-1:0]                        cnt_q;
  logic [NCHAN-1:0][DATA_WIDTH-1:0]     shift_q;

`ifdef SIO_ATE_PARITY_EN
  logic [NCHAN-1:0]                     par_q;
  logic [NCHAN-1:0]                     par_d;

  always_comb begin
    par_d = '0;
    for (int c = 0; c < NCHAN; c++) begin
      par_d[c] = ^TestWord[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end
`endif

  always_ff @(posedge SioClk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      SioDat     <= '0;
      Busy       <= 1'b0;
      FrameDone  <= 1'b0;
      FrameCount <= '0;
`ifdef SIO_ATE_PARITY_EN
      par_q      <= '0;
`endif
    end else begin
      FrameDone <= 1'b0;
      case (state_q)
        S_IDLE: begin
          SioDat <= '0;
          Busy   <= 1'b0;
          cnt_q  <= '0;
          if (Start || Continuous) begin
            state_q <= S_PRE;
          end
        end

        S_PRE: begin
          SioDat <= '0;
          Busy   <= 1'b1;
          if (cnt_q == PRE_LAST) begin
            cnt_q   <= '0;
            state_q <= S_START;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_START: begin
          SioDat <= '1;
          Busy   <= 1'b1;
          cnt_q  <= '0;
          for (int c = 0; c < NCHAN; c++) begin
            shift_q[c] <= TestWord[c*DATA_WIDTH +: DATA_WIDTH];
          end
`ifdef SIO_ATE_PARITY_EN
          par_q <= par_d;
`endif
          state_q <= S_DATA;
        end

        S_DATA: begin
          Busy <= 1'b1;
          for (int c = 0; c < NCHAN; c++) begin
            SioDat[c]  <= shift_q[c][DATA_WIDTH-1];
            shift_q[c] <= shift_q[c] << 1;
          end
          if (cnt_q == DATA_LAST) begin
            cnt_q <= '0;
`ifdef SIO_ATE_PARITY_EN
            state_q <= S_PARITY;
`else
            FrameDone  <= 1'b1;
            FrameCount <= FrameCount + 1'b1;
            state_q    <= Continuous ? S_PRE : S_IDLE;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

`ifdef SIO_ATE_PARITY_EN
        S_PARITY: begin
          Busy       <= 1'b1;
          SioDat     <= par_q;
          FrameDone  <= 1'b1;
          FrameCount <= FrameCount + 1'b1;
          cnt_q      <= '0;
          state_q    <= Continuous ? S_PRE : S_IDLE;
        end
`endif

        default: begin
          SioDat  <= '0;
          Busy    <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sio_ate_gen.sv
// ============================================================================
// tb_sio_ate_gen : self-checking bench for sio_ate_gen (observable-level model).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sio_ate_gen;

  localparam int DW   = 10;
  localparam int PL   = 20;
  localparam int NCH  = 2;
  localparam int CNTW = 4;
`ifdef SIO_ATE_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = PL + 1 + DW + PAR;

  logic              clk   = 1'b0;
  logic              rst   = 1'b1;
  logic              start = 1'b0;
  logic              cont  = 1'b0;
  logic [NCH*DW-1:0] tw    = '0;
  logic [NCH-1:0]    sio;
  logic              busy;
  logic              done;
  logic [CNTW-1:0]   fcnt;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sio_ate_gen #(
    .DATA_WIDTH   (DW),
    .PREAMBLE_LEN (PL),
    .NCHAN        (NCH),
    .CNT_WIDTH    (CNTW)
  ) dut (
    .SioClk     (clk),
    .Reset      (rst),
    .Start      (start),
    .Continuous (cont),
    .TestWord   (tw),
    .SioDat     (sio),
    .Busy       (busy),
    .FrameDone  (done),
    .FrameCount (fcnt)
  );

  // Reference model: 'show' is the frame position presented after the
  // current edge (-1 = idle); the decision for the next edge is taken from
  // the inputs seen at this edge.
  int             show      = -1;
  int             next_show = -1;
  int             mcount    = 0;
  logic [DW-1:0]  mword [NCH];
  logic [NCH-1:0] e_dat  = '0;
  logic           e_busy = 1'b0;
  logic           e_done = 1'b0;

  function automatic logic frame_bit(input int p, input logic [DW-1:0] w);
    if (p < 0)        return 1'b0;
    if (p < PL)       return 1'b0;
    if (p == PL)      return 1'b1;
    if (p <= PL + DW) return w[DW-1-(p-PL-1)];
    return ^w;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      show      = -1;
      next_show = -1;
      mcount    = 0;
      e_dat     = '0;
      e_busy    = 1'b0;
      e_done    = 1'b0;
    end else begin
      show   = next_show;
      e_busy = (show >= 0);
      e_done = (show == FL - 1);
      if (e_done) mcount = (mcount + 1) % (1 << CNTW);
      if (show == PL) begin
        for (int c = 0; c < NCH; c++) mword[c] = tw[c*DW +: DW];
      end
      for (int c = 0; c < NCH; c++) e_dat[c] = frame_bit(show, mword[c]);
      if (show == FL - 1)  next_show = cont ? 0 : -1;
      else if (show >= 0)  next_show = show + 1;
      else                 next_show = (start || cont) ? 0 : -1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if ({sio, busy, done, fcnt} !== {e_dat, e_busy, e_done, mcount[CNTW-1:0]}) begin
        n_err++;
        $display("FAIL cycle t=%0t: got dat=%b busy=%b done=%b cnt=%0d, expected dat=%b busy=%b done=%b cnt=%0d",
                 $time, sio, busy, done, fcnt, e_dat, e_busy, e_done, mcount);
      end
    end
  end

  // Capture buffers for the directed, hand-computed checks.
  logic rec0 [0:127];
  logic rec1 [0:127];
  logic recb [0:127];
  logic recd [0:127];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sample(input int k);
    rec0[k] = sio[0];
    rec1[k] = sio[1];
    recb[k] = busy;
    recd[k] = done;
  endtask

  task automatic capture(input int n, input int drop_cont_at);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      sample(k);
      if (k == 0) start = 1'b0;
      if (k == drop_cont_at) cont = 1'b0;
    end
  endtask

  function automatic logic [63:0] pack(input int ch, input int lo, input int n);
    logic [63:0] r = '0;
    for (int i = 0; i < n; i++) r = {r[62:0], (ch == 0) ? rec0[lo+i] : rec1[lo+i]};
    return r;
  endfunction

  function automatic int count_of(input int which, input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += (which == 0) ? int'(recb[i]) : int'(recd[i]);
    return s;
  endfunction

  function automatic logic [63:0] exp_frame(input logic [DW-1:0] w);
    logic [63:0] r;
    r = {33'd0, 21'd1, w};
    if (PAR != 0) r = {r[62:0], ^w};
    return r;
  endfunction

  logic [31:0] rnd;

  initial begin
    // Reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_dat",  64'(sio),  64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_cnt",  64'(fcnt), 64'd0);
    chk_en = 1'b1;
    rst    = 1'b0;
    @(negedge clk);

    // Reset at data bit 5 aborts the frame
    tw    = {10'h000, 10'h355};
    start = 1'b1;
    for (int k = 0; k <= 26; k++) begin
      @(negedge clk);
      sample(k);
      if (k == 0) start = 1'b0;
    end
    check("abort_bit5", 64'(rec0[26]), 64'd0);
    check("abort_busy_before", 64'(recb[26]), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_dat",  64'(sio),  64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_cnt",  64'(fcnt), 64'd0);
    repeat (3) @(negedge clk);

    // Single shot: ch0 0x355, ch1 0x354
    tw    = {10'h354, 10'h355};
    start = 1'b1;
    capture(FL + 8, -1);
    check("single_ch0_seq", pack(0, 1, 31), 64'h755);
    check("single_ch1_seq", pack(1, 1, 31), 64'h754);
    check("single_busy_len", 64'(count_of(0, FL + 8)), 64'(FL));
    check("single_done_cnt", 64'(count_of(1, FL + 8)), 64'd1);
    check("single_done_pos", 64'(recd[FL]), 64'd1);
    check("single_framecnt", 64'(fcnt), 64'd1);
    if (PAR != 0) begin
      check("parity_0x355", 64'(rec0[32]), 64'd0);
      check("parity_0x354", 64'(rec1[32]), 64'd1);
    end

    // Continuous: 3 back-to-back frames
    tw   = {10'h000, 10'h3FF};
    cont = 1'b1;
    capture(3 * FL + 20, 2 * FL + 8);
    check("cont_busy_len", 64'(count_of(0, 3 * FL + 20)), 64'(3 * FL));
    check("cont_done_cnt", 64'(count_of(1, 3 * FL + 20)), 64'd3);
    check("cont_done_pos", 64'({recd[FL], recd[2*FL], recd[3*FL]}), 64'b111);
    check("cont_no_gap", 64'(recb[FL+1]), 64'd1);
    check("cont_frame2", pack(0, FL + 1, FL), exp_frame(10'h3FF));
    check("cont_framecnt", 64'(fcnt), 64'd4);

    // Two channels, opposite words, aligned start bits
    tw    = {10'h000, 10'h3FF};
    start = 1'b1;
    capture(FL + 4, -1);
    check("nch_ch0", pack(0, 1, FL), exp_frame(10'h3FF));
    check("nch_ch1", pack(1, 1, FL), exp_frame(10'h000));
    check("nch_start_aligned", 64'({rec0[PL+1], rec1[PL+1], rec0[PL], rec1[PL]}), 64'b1100);
    check("nch_framecnt", 64'(fcnt), 64'd5);

    // Start held; TestWord changed in preamble and again in data
    tw    = {10'h000, 10'h355};
    start = 1'b1;
    for (int k = 0; k < 2 * FL + 11; k++) begin
      @(negedge clk);
      sample(k);
      if (k == 5)      tw = {10'h000, 10'h0AA};
      if (k == 25)     tw = {10'h000, 10'h123};
      if (k == FL + 3) start = 1'b0;
    end
    check("held_frame1", pack(0, 1, FL), exp_frame(10'h0AA));
    check("held_idle_gap", 64'({recb[FL], recb[FL+1], recb[FL+2]}), 64'b101);
    check("held_frame2", pack(0, FL + 2, FL), exp_frame(10'h123));
    check("held_framecnt", 64'(fcnt), 64'd7);

    // FrameCount wrap: 20 continuous frames from 7 -> 27 mod 16
    cont = 1'b1;
    repeat (1 + FL * 19 + 5) @(negedge clk);
    cont = 1'b0;
    repeat (FL + 10) @(negedge clk);
    check("wrap_framecnt", 64'(fcnt), 64'd11);
    check("wrap_idle", 64'(busy), 64'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rnd   = $urandom;
      tw    = rnd[NCH*DW-1:0];
      start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 63) == 0) cont = ~cont;
      rst   = ($urandom_range(0, 499) == 0);
    end
    rst   = 1'b0;
    start = 1'b0;
    cont  = 1'b0;
    repeat (2 * FL + 5) @(negedge clk);
    check("final_idle", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
